counter: RTL and testbench
==========================

// Module: counter
//
// PURPOSE
//   Parameterised W-bit synchronous up/down counter with count enable.
//   Generic event/cycle counter building block used wherever a free-running
//   or direction-controlled count is needed.
//   Single clock domain. Output is registered straight from the count register.
//
// PARAMETERS
//   W      8     width of the count register and of cnt; legal range W >= 1
//
// PORTS
//   clk    input   1     clock; all state updates on the rising edge
//   rst_n  input   1     reset, asynchronous, active-low
//   up     input   1     direction: 1 = increment, 0 = decrement
//   en     input   1     count enable: 1 = count this cycle, 0 = hold
//   cnt    output  W     current count value, unsigned
//
// BEHAVIOUR
//   - One clock (clk). Reset rst_n is asynchronous and active-low.
//   - Reset:
//     - rst_n low forces cnt to 0 immediately, independent of clk.
//     - cnt holds 0 while rst_n is low, regardless of en and up.
//     - After rst_n rises, the first counting action occurs on the next rising clk edge.
//   - Per rising edge, with rst_n high:
//     - en=1, up=1: cnt <= cnt + 1
//     - en=1, up=0: cnt <= cnt - 1
//     - en=0: cnt holds (up is ignored)
//   - Latency: one cycle. Inputs sampled at an edge are reflected on cnt right after that edge.
//   - Arithmetic is modulo 2^W:
//     - Incrementing from 2^W-1 wraps to 0.
//     - Decrementing from 0 wraps to 2^W-1.
//     - No saturation and no overflow flag.
//   - Direction change takes effect on the very edge where the new up value is
//     sampled. There is no dead cycle and no pipeline.
//   - Reset asserted mid-count clears cnt at once and overrides all other inputs.
//   - No handshake and no internal state other than the W-bit count register.
//
// TESTING
//   1. Reset with en=0, up=1, rst_n=0 for 1 cycle -> cnt=0.
//      cnt stays 0 while rst_n=0, even with en=1.
//   2. Count up: after reset release, en=1 up=1 for 9 rising edges -> cnt=9.
//      10 more edges -> cnt=19.
//   3. Count down: from cnt=20, en=1 up=0 for 9 edges -> cnt=11.
//      One more edge -> 10. Then en=0 for 10 edges -> cnt holds 10.
//   4. Wrap (W=8): up from 255 -> 0. Down from 0 -> 255.
//      With W=4: up from 15 -> 0.
//   5. Async reset mid-count: from cnt=37, assert rst_n between edges
//      -> cnt=0 before the next edge. Counting resumes from 0 after release.
//   6. Enable gating: toggle en every cycle with up=1 for 10 edges -> cnt=5.
//      Toggling up with en=0 -> no change.

Source files
------------

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module      : counter
// Description : Parameterised W-bit synchronous up/down counter with count
//               enable. Arithmetic wraps modulo 2^W; cnt comes directly
//               from the count register.
// Revision    : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Unit step at full register width, so it also works when W is 1.
  localparam logic [W-1:0] c_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step in the requested direction when enabled, otherwise hold.
  // The wrap at either end comes from the natural overflow of W-bit math.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (up) begin
        cnt_d = cnt_q + c_ONE;
      end else begin
        cnt_d = cnt_q - c_ONE;
      end
    end
  end

  // Count register. Reset clears it at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter
// Description : Self-checking bench for counter. Stimulus pushes expected
//               counts into a scoreboard queue; a monitor pops and compares.
//               Two instances are exercised: W=8 and W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       up8;
  logic       en8;
  logic [7:0] cnt8;
  logic       up4;
  logic       en4;
  logic [3:0] cnt4;

  counter #(.W(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .up   (up8),
    .en   (en8),
    .cnt  (cnt8)
  );

  counter #(.W(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .up   (up4),
    .en   (en4),
    .cnt  (cnt4)
  );

  // 10 time-unit clock period; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is4;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   total  = 0;
  int   passed = 0;

  // Reference counts, advanced in the stimulus process only.
  int   m8 = 0;
  int   m4 = 0;

  // Monitor: drains the scoreboard each time the stimulus marks a sample point.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = e.is4 ? {4'b0000, cnt4} : cnt8;
        total++;
        if (act === e.val) begin
          passed++;
        end else begin
          $display("FAIL %s: cnt=%0d expected=%0d (t=%0t)", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic push(input bit is4, input int val, input string name);
    exp_t e;
    e.is4  = is4;
    e.val  = 8'(val);
    e.name = name;
    q.push_back(e);
  endtask

  // Drive one cycle's inputs, let one rising edge pass, advance the reference
  // counts, and queue the expected values of both counters.
  task automatic step(input bit e8, input bit u8, input bit e4, input bit u4,
                      input string name);
    en8 = e8; up8 = u8; en4 = e4; up4 = u4;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m8 = 0;
      m4 = 0;
    end else begin
      if (e8) m8 = u8 ? (m8 + 1) % 256 : (m8 + 255) % 256;
      if (e4) m4 = u4 ? (m4 + 1) % 16  : (m4 + 15) % 16;
    end
    push(1'b0, m8, {name, "/w8"});
    push(1'b1, m4, {name, "/w4"});
    -> chk_ev;
  endtask

  // Directed check of a hand-computed value at the current sample point.
  task automatic expect_now(input bit is4, input int val, input string name);
    push(is4, val, name);
    -> chk_ev;
    #0;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    en8 = 1'b0; up8 = 1'b1; en4 = 1'b0; up4 = 1'b1;

    // 1. Reset: held at zero, even with enable high.
    step(0, 1, 0, 1, "reset_idle");
    expect_now(0, 0, "reset_zero");
    step(1, 1, 1, 1, "reset_en_high");
    expect_now(0, 0, "reset_hold_en");
    expect_now(1, 0, "reset_hold_en4");
    #2 rst_n = 1'b1;

    // 2. Count up: 9 edges -> 9, 10 more -> 19.
    for (int i = 0; i < 9; i++) step(1, 1, 0, 1, "up_a");
    expect_now(0, 9, "up_to_9");
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1, "up_b");
    expect_now(0, 19, "up_to_19");

    // 3. Count down from 20: 9 edges -> 11, one more -> 10, then hold.
    step(1, 1, 0, 1, "up_to_20");
    expect_now(0, 20, "at_20");
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, "down_a");
    expect_now(0, 11, "down_to_11");
    step(1, 0, 0, 1, "down_b");
    expect_now(0, 10, "down_to_10");
    for (int i = 0; i < 10; i++) step(0, i[0], 0, 1, "hold");
    expect_now(0, 10, "hold_10");

    // 4. Wrap on W=8 both ways; W=4 wraps up from 15.
    for (int i = 0; i < 245; i++) step(1, 1, 0, 1, "climb");
    expect_now(0, 255, "at_255");
    step(1, 1, 0, 1, "wrap_up");
    expect_now(0, 0, "wrap_255_to_0");
    step(1, 0, 0, 1, "wrap_down");
    expect_now(0, 255, "wrap_0_to_255");
    for (int i = 0; i < 15; i++) step(0, 1, 1, 1, "w4_climb");
    expect_now(1, 15, "w4_at_15");
    step(0, 1, 1, 1, "w4_wrap");
    expect_now(1, 0, "w4_wrap_15_to_0");
    expect_now(0, 255, "w8_held_255");

    // 5. Async reset mid-count from 37.
    step(1, 1, 0, 1, "to_0");
    for (int i = 0; i < 37; i++) step(1, 1, 0, 1, "to_37");
    expect_now(0, 37, "at_37");
    #2 rst_n = 1'b0;
    #1;
    m8 = 0; m4 = 0;
    expect_now(0, 0, "async_clear_between_edges");
    step(1, 1, 1, 1, "reset_held");
    #2 rst_n = 1'b1;
    step(1, 1, 0, 1, "resume");
    expect_now(0, 1, "resume_from_0");

    // 6. Enable gating: en toggles over 10 edges -> 5 counts; up toggles with en=0.
    rst_n = 1'b0;
    step(0, 1, 0, 1, "reset6");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(~i[0], 1, 0, 1, "en_toggle");
    expect_now(0, 5, "en_toggle_5");
    for (int i = 0; i < 6; i++) step(0, i[0], 0, i[0], "up_toggle_en0");
    expect_now(0, 5, "up_toggle_hold");

    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
